// File: rtl/stage_memory.sv
// Memory stage: runs scalar and vector loads/stores as 32-bit Avalon-MM beats,
// stalls the front of the pipe while the access runs and registers the writeback bundle.
module stage_memory #(
    parameter int VLANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_reg_write,
    input  logic         mem_mem_write,
    input  logic         mem_mem_read,
    input  logic [1:0]   mem_result_src,
    input  logic         mem_vector_op,
    input  logic [127:0] mem_alu_result,
    input  logic [127:0] mem_write_data,
    input  logic [4:0]   mem_rd,
    input  logic [31:0]  mem_pc_plus_4,
    output logic         mem_stall,
    output logic [31:0]  avm_address,
    output logic         avm_read,
    output logic         avm_write,
    output logic [31:0]  avm_writedata,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_waitrequest,
    output logic         wb_reg_write,
    output logic [4:0]   wb_rd,
    output logic [1:0]   wb_result_src,
    output logic [127:0] wb_alu_result,
    output logic [127:0] wb_read_data,
    output logic [31:0]  wb_pc_plus_4
);

    localparam int BW = (VLANES > 1) ? $clog2(VLANES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BW-1:0]   beat;
    logic [BW-1:0]   beat_inc;
    logic [BW-1:0]   last;
    logic            memop;
    logic            accept;
    logic [31:0]     base;
    logic [127:0]    rd_buf;

    always_comb begin
        memop    = mem_mem_read | mem_mem_write;
        last     = mem_vector_op ? BW'(VLANES - 1) : '0;
        base     = {mem_alu_result[31:2], 2'b00};
        accept   = (state == ACCESS) && !avm_waitrequest;
        beat_inc = beat + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Stall is combinational so the op is frozen in the same cycle it arrives;
    // it is forced low while reset is asserted.
    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (memop) begin
                    state_nxt = ACCESS;
                    mem_stall = 1'b1;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (accept && (beat == last)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        mem_stall = mem_stall & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat          <= '0;
            rd_buf        <= '0;
            avm_address   <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            wb_result_src <= '0;
            wb_alu_result <= '0;
            wb_read_data  <= '0;
            wb_pc_plus_4  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wb_reg_write  <= mem_reg_write & ~memop;
                    wb_rd         <= mem_rd;
                    wb_result_src <= mem_result_src;
                    wb_alu_result <= mem_alu_result;
                    wb_pc_plus_4  <= mem_pc_plus_4;
                    wb_read_data  <= '0;
                    if (memop) begin
                        beat          <= '0;
                        rd_buf        <= '0;
                        avm_address   <= base;
                        avm_writedata <= mem_write_data[31:0];
                        avm_read      <= mem_mem_read;
                        avm_write     <= mem_mem_write & ~mem_mem_read;
                    end
                end
                ACCESS: begin
                    wb_reg_write <= 1'b0;
                    if (!avm_waitrequest) begin
                        if (avm_read) rd_buf[{beat, 5'b0} +: 32] <= avm_readdata;
                        if (beat != last) begin
                            // Next beat goes out back-to-back with the request held high.
                            beat          <= beat_inc;
                            avm_address   <= avm_address + 32'd4;
                            avm_writedata <= mem_write_data[{beat_inc, 5'b0} +: 32];
                        end else begin
                            avm_read  <= 1'b0;
                            avm_write <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    beat          <= '0;
                    wb_reg_write  <= mem_reg_write;
                    wb_rd         <= mem_rd;
                    wb_result_src <= mem_result_src;
                    wb_alu_result <= mem_alu_result;
                    wb_pc_plus_4  <= mem_pc_plus_4;
                    wb_read_data  <= rd_buf;
                end
                default: begin
                    wb_reg_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: table of non-memory ops plus hand-built load/store sequences
// against a small Avalon slave, with expected transfers and writebacks kept in queues.
module tb_stage_memory;

    logic         clk;
    logic         rst_n;
    logic         mem_reg_write;
    logic         mem_mem_write;
    logic         mem_mem_read;
    logic [1:0]   mem_result_src;
    logic         mem_vector_op;
    logic [127:0] mem_alu_result;
    logic [127:0] mem_write_data;
    logic [4:0]   mem_rd;
    logic [31:0]  mem_pc_plus_4;
    logic         mem_stall;
    logic [31:0]  avm_address;
    logic         avm_read;
    logic         avm_write;
    logic [31:0]  avm_writedata;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;
    logic         wb_reg_write;
    logic [4:0]   wb_rd;
    logic [1:0]   wb_result_src;
    logic [127:0] wb_alu_result;
    logic [127:0] wb_read_data;
    logic [31:0]  wb_pc_plus_4;

    stage_memory #(.VLANES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_reg_write(mem_reg_write), .mem_mem_write(mem_mem_write),
        .mem_mem_read(mem_mem_read), .mem_result_src(mem_result_src),
        .mem_vector_op(mem_vector_op), .mem_alu_result(mem_alu_result),
        .mem_write_data(mem_write_data), .mem_rd(mem_rd),
        .mem_pc_plus_4(mem_pc_plus_4), .mem_stall(mem_stall),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result_src(wb_result_src),
        .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data),
        .wb_pc_plus_4(wb_pc_plus_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         reg_write;
        logic [4:0]   rd;
        logic [1:0]   src;
        logic [127:0] alu;
        logic [127:0] rdata;
        logic [31:0]  pc;
    } wb_exp_t;

    typedef struct {
        logic         reg_write;
        logic [4:0]   rd;
        logic [1:0]   src;
        logic [127:0] alu;
        logic [31:0]  pc;
    } nm_vec_t;

    wb_exp_t     exp_wb_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_wdata_q[$];
    nm_vec_t     nm_tab[4];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        mem_reg_write  = 1'b0;
        mem_mem_write  = 1'b0;
        mem_mem_read   = 1'b0;
        mem_result_src = 2'b00;
        mem_vector_op  = 1'b0;
        mem_alu_result = '0;
        mem_write_data = '0;
        mem_rd         = '0;
        mem_pc_plus_4  = '0;
    endtask

    // Called #1 after the edge that follows the cycle producing the writeback.
    task automatic check_wb(input string tag);
        wb_exp_t e;
        if (exp_wb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_wb_queue: got empty expected entry", tag);
            return;
        end
        e = exp_wb_q.pop_front();
        check({tag, "_wb_reg_write"}, 128'(wb_reg_write), 128'(e.reg_write));
        check({tag, "_wb_rd"}, 128'(wb_rd), 128'(e.rd));
        check({tag, "_wb_result_src"}, 128'(wb_result_src), 128'(e.src));
        check({tag, "_wb_alu_result"}, wb_alu_result, e.alu);
        check({tag, "_wb_read_data"}, wb_read_data, e.rdata);
        check({tag, "_wb_pc_plus_4"}, 128'(wb_pc_plus_4), 128'(e.pc));
    endtask

    // Entered #1 after a rising edge; leaves #1 after the edge that registers the writeback.
    task automatic apply_nm(input nm_vec_t v, input string tag);
        wb_exp_t e;
        mem_reg_write  = v.reg_write;
        mem_mem_write  = 1'b0;
        mem_mem_read   = 1'b0;
        mem_vector_op  = 1'b0;
        mem_rd         = v.rd;
        mem_result_src = v.src;
        mem_alu_result = v.alu;
        mem_pc_plus_4  = v.pc;
        e = '{reg_write: v.reg_write, rd: v.rd, src: v.src, alu: v.alu, rdata: '0, pc: v.pc};
        exp_wb_q.push_back(e);
        @(negedge clk);
        check({tag, "_stall"}, 128'(mem_stall), 128'(0));
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    task automatic mem_op(input logic rd_en, input logic wr_en, input logic vec,
                          input logic [31:0] addr, input logic [127:0] wdata,
                          input logic [127:0] rlanes, input int wait_beat,
                          input int wait_cycles, input logic reg_write,
                          input logic [4:0] rd, input string tag);
        int          n;
        int          beats;
        int          waits;
        int          stall_n;
        int          req_n;
        int          cyc;
        bit          done;
        logic        is_wr;
        logic [31:0] base;
        logic [31:0] a;
        logic [31:0] d;
        wb_exp_t     e;
        n     = vec ? 4 : 1;
        is_wr = wr_en & ~rd_en;
        base  = {addr[31:2], 2'b00};
        mem_reg_write  = reg_write;
        mem_mem_read   = rd_en;
        mem_mem_write  = wr_en;
        mem_vector_op  = vec;
        mem_result_src = 2'($urandom_range(0, 3));
        mem_alu_result = {$urandom(), $urandom(), $urandom(), addr};
        mem_write_data = wdata;
        mem_rd         = rd;
        mem_pc_plus_4  = 32'h0000_1000 + addr;
        for (int b = 0; b < n; b++) begin
            exp_addr_q.push_back(base + 32'(4 * b));
            exp_wdata_q.push_back(wdata[32*b +: 32]);
        end
        e.reg_write = reg_write;
        e.rd        = rd;
        e.src       = mem_result_src;
        e.alu       = mem_alu_result;
        e.pc        = mem_pc_plus_4;
        e.rdata     = rd_en ? (vec ? rlanes : {96'b0, rlanes[31:0]}) : 128'b0;
        exp_wb_q.push_back(e);
        beats = 0; waits = 0; stall_n = 0; req_n = 0; cyc = 0; done = 0;
        while (!done && cyc < 40) begin
            avm_waitrequest = (avm_read | avm_write) && (beats == wait_beat) && (waits < wait_cycles);
            if (!avm_waitrequest && beats < n) avm_readdata = rlanes[32*beats +: 32];
            else avm_readdata = $urandom();
            @(negedge clk);
            cyc++;
            if (mem_stall) stall_n++;
            if (avm_read | avm_write) begin
                req_n++;
                check({tag, "_avm_read"}, 128'(avm_read), 128'(rd_en));
                check({tag, "_avm_write"}, 128'(avm_write), 128'(is_wr));
                if (beats < n) begin
                    check({tag, "_addr_hold"}, 128'(avm_address), 128'(base + 32'(4 * beats)));
                    if (is_wr) check({tag, "_wdata_hold"}, 128'(avm_writedata), 128'(wdata[32*beats +: 32]));
                end
                if (!avm_waitrequest) begin
                    if (exp_addr_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL %s_extra_beat: got beat %0d expected at most %0d", tag, beats + 1, n);
                    end else begin
                        a = exp_addr_q.pop_front();
                        d = exp_wdata_q.pop_front();
                        check({tag, "_beat_addr"}, 128'(avm_address), 128'(a));
                        if (is_wr) check({tag, "_beat_wdata"}, 128'(avm_writedata), 128'(d));
                    end
                    beats++;
                end else begin
                    waits++;
                end
            end
            if (!mem_stall) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        avm_waitrequest = 1'b0;
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: got stall after %0d cycles expected release", tag, cyc);
            exp_addr_q.delete();
            exp_wdata_q.delete();
            exp_wb_q.delete();
            return;
        end
        check({tag, "_req_after_last"}, 128'(avm_read | avm_write), 128'(0));
        check({tag, "_stall_cycles"}, 128'(stall_n), 128'(1 + n + wait_cycles));
        check({tag, "_req_cycles"}, 128'(req_n), 128'(n + wait_cycles));
        check({tag, "_beats"}, 128'(beats), 128'(n));
        @(posedge clk);
        #1;
        check_wb(tag);
    endtask

    initial begin
        logic [127:0] wd;
        logic [127:0] rl;
        logic         v;
        logic         r;
        int           wc;

        nm_tab[0] = '{reg_write: 1'b1, rd: 5'd5, src: 2'b00, alu: {96'hA5A5_0000_1111_2222_3333_4444, 32'h0000_002A}, pc: 32'h0000_0104};
        nm_tab[1] = '{reg_write: 1'b0, rd: 5'd31, src: 2'b10, alu: {4{32'hFFFF_FFFF}}, pc: 32'hFFFF_FFFC};
        nm_tab[2] = '{reg_write: 1'b1, rd: 5'd1, src: 2'b11, alu: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, pc: 32'h0000_0008};
        nm_tab[3] = '{reg_write: 1'b1, rd: 5'd0, src: 2'b01, alu: '0, pc: 32'h8000_0000};

        rst_n           = 1'b0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        set_nop();
        mem_reg_write  = 1'b1;
        mem_rd         = 5'd7;
        mem_alu_result = 128'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_stall", 128'(mem_stall), 128'(0));
        check("rst_avm_read", 128'(avm_read), 128'(0));
        check("rst_avm_write", 128'(avm_write), 128'(0));
        check("rst_avm_address", 128'(avm_address), 128'(0));
        check("rst_wb_reg_write", 128'(wb_reg_write), 128'(0));
        check("rst_wb_rd", 128'(wb_rd), 128'(0));
        check("rst_wb_alu_result", wb_alu_result, 128'(0));
        check("rst_wb_read_data", wb_read_data, 128'(0));
        set_nop();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) apply_nm(nm_tab[i], $sformatf("nm%0d", i));

        mem_op(1, 0, 0, 32'h0000_0103, '0, {96'b0, 32'hDEAD_BEEF}, 0, 0, 1, 5'd3, "sload");
        set_nop();
        @(posedge clk);
        #1;
        wd = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        mem_op(0, 1, 1, 32'h0000_0200, wd, '0, 1, 2, 0, 5'd9, "vstore");
        mem_op(1, 0, 1, 32'h0000_0300, '0, {32'd4, 32'd3, 32'd2, 32'd1}, 0, 0, 1, 5'd10, "vload");

        // Back-to-back: upper lanes of the final scalar load must come back zero.
        mem_op(1, 0, 0, 32'h0000_0040, '0, {96'b0, 32'h1234_5678}, 0, 0, 1, 5'd11, "b2b_s");
        mem_op(1, 0, 1, 32'h0000_0080, '0, {32'hA4, 32'hA3, 32'hA2, 32'hA1}, 2, 1, 1, 5'd12, "b2b_v");
        mem_op(1, 0, 0, 32'h0000_0046, '0, {96'b0, 32'h0BAD_F00D}, 0, 0, 1, 5'd13, "b2b_s2");

        mem_op(1, 1, 0, 32'h0000_0500, {4{32'h5555_AAAA}}, {96'b0, 32'h7777_8888}, 0, 1, 1, 5'd14, "rdprio");

        for (int i = 0; i < 6; i++) begin
            v  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wc = $urandom_range(0, 3);
            wd = {$urandom(), $urandom(), $urandom(), $urandom()};
            rl = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (!v) rl[127:32] = '0;
            mem_op(r, !r, v, 32'($urandom_range(0, 4095)), wd, rl,
                   v ? $urandom_range(0, 3) : 0, wc, r, 5'($urandom_range(1, 31)),
                   $sformatf("rnd%0d", i));
        end

        // Reset while beat 2 of a vector load is on the bus.
        mem_reg_write  = 1'b1;
        mem_mem_read   = 1'b1;
        mem_vector_op  = 1'b1;
        mem_rd         = 5'd20;
        mem_alu_result = 128'h0000_0600;
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h1111_2222;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("mid_rst_pre_read", 128'(avm_read), 128'(1));
        check("mid_rst_pre_addr", 128'(avm_address), 128'(32'h0000_0608));
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_avm_read", 128'(avm_read), 128'(0));
        check("mid_rst_stall", 128'(mem_stall), 128'(0));
        check("mid_rst_wb_reg_write", 128'(wb_reg_write), 128'(0));
        set_nop();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_wb_reg_write%0d", i), 128'(wb_reg_write), 128'(0));
            check($sformatf("post_rst_stall%0d", i), 128'(mem_stall), 128'(0));
            check($sformatf("post_rst_avm_read%0d", i), 128'(avm_read), 128'(0));
        end
        @(posedge clk);
        #1;
        apply_nm(nm_tab[0], "post_rst_nm");
        mem_op(1, 0, 0, 32'h0000_0700, '0, {96'b0, 32'hCAFE_0001}, 0, 0, 1, 5'd21, "post_rst_sload");

        set_nop();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Memory stage of the 5-stage vector core, between execute and writeback.
- Executes scalar (32-bit) and vector (128-bit) loads and stores as 32-bit Avalon-MM master transfers.
- Vector accesses are split into 4 sequential word beats.
- Produces the wb_* bundle that drives the register-file write port in decode, and a stall to the hazard unit.

Parameters:
- VLANES, 4, number of 32-bit lanes per vector access (fixed at 4; beat counter sized to match)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mem_reg_write  in  1  instruction writes rd
- mem_mem_write  in  1  store request
- mem_mem_read  in  1  load request
- mem_result_src  in  2  writeback mux select, passed through
- mem_vector_op  in  1  1 = 128-bit access (4 beats), 0 = scalar (1 beat)
- mem_alu_result  in  128  ALU result; bits [31:0] are the byte address for memory ops
- mem_write_data  in  128  store data; lane i = bits [32i+31:32i]
- mem_rd  in  5  destination register
- mem_pc_plus_4  in  32  passed through
- mem_stall  out  1  freeze PC/IF/DE/EX registers (to hazard unit)
- avm_address  out  32  Avalon byte address, word aligned
- avm_read  out  1  Avalon read
- avm_write  out  1  Avalon write
- avm_writedata  out  32  Avalon write data
- avm_readdata  in  32  Avalon read data, valid when avm_read=1 and avm_waitrequest=0
- avm_waitrequest  in  1  slave not ready; hold request
- wb_reg_write  out  1  to writeback / register file we3
- wb_rd  out  5  to writeback
- wb_result_src  out  2  to writeback
- wb_alu_result  out  128  to writeback
- wb_read_data  out  128  load data to writeback
- wb_pc_plus_4  out  32  to writeback

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, beat=0, read buffer=0.
  - All outputs 0: avm_read/avm_write drop immediately, mem_stall=0, all wb_* = 0.
  - Reset mid-transfer abandons the access; no writeback is produced.
- memop = mem_mem_read | mem_mem_write. If both are set, the read takes priority and avm_write stays 0.
- last = VLANES-1 if mem_vector_op, else 0.
- base = {mem_alu_result[31:2], 2'b00}; address bits [1:0] are ignored.
- IDLE:
  - No memop: wb_* register the inputs every cycle; wb_read_data <= 0; mem_stall=0.
  - memop: go to ACCESS; register avm_address=base, avm_writedata=lane0, and avm_read or avm_write =1; beat=0.
  - mem_stall=1 (combinational); wb_reg_write <= 0 (bubble).
- ACCESS, avm_waitrequest=1: hold all avm_* outputs stable; mem_stall=1; wb bubble.
- ACCESS, avm_waitrequest=0 (beat accepted):
  - On a read, capture avm_readdata into buffer lane[beat].
  - If beat<last: beat++, avm_address += 4, avm_writedata = lane[beat+1]; request stays asserted with no idle cycle between beats.
  - If beat==last: deassert avm_read/avm_write at the edge; go to DONE.
  - mem_stall=1 throughout ACCESS.
- DONE:
  - mem_stall=0.
  - wb_* capture the inputs, which are still held by the stall.
  - wb_read_data = buffer; scalar loads put data in lane 0 with upper 96 bits zero.
  - Stores complete with wb_reg_write = mem_reg_write (normally 0).
  - Next state IDLE. The next instruction is presented the following cycle, so there is no reissue.
- Latency:
  - Non-memory instruction: 1 cycle, no stall.
  - Memory op: 2 + N + W cycles in stage, where N = beats (1 or 4) and W = waitrequest cycles; mem_stall is high for 1 + N + W cycles.
- Buffer lanes not written in a scalar load are zero; the buffer is cleared on entry to ACCESS.
- Inputs must stay stable while mem_stall=1; this stage assumes the hazard unit guarantees it and does not re-sample them.

Test Plan:
- Reset mid-vector-load at beat 2, with avm_read=1 -> avm_read=0 immediately; after release, state IDLE, wb_reg_write=0, no spurious writeback.
- Non-memory op: mem_reg_write=1, rd=5, alu_result=0x..._0000002A -> next cycle wb_rd=5, wb_alu_result matches, wb_reg_write=1, mem_stall never asserted.
- Scalar load, addr 0x103, no waitrequest, readdata=0xDEADBEEF:
  - avm_address=0x100, avm_read high exactly 1 cycle.
  - mem_stall high 2 cycles.
  - wb_read_data=0x...0000_DEADBEEF with upper 96 bits zero; wb_reg_write=1.
- Vector store, addr 0x200, data {D,C,B,A}, waitrequest=1 for 2 cycles on beat 1:
  - Writes A@0x200, B@0x204, C@0x208, D@0x20C in order.
  - avm_address/avm_writedata held during the wait; mem_stall high 7 cycles; wb_reg_write=0.
- Vector load, addr 0x300, readdata 1,2,3,4 per beat -> wb_read_data = {4,3,2,1}; no extra avm_read after beat 3.
- Back-to-back: scalar load followed immediately by vector load -> second access starts from IDLE the cycle after DONE with beat reset to 0 and buffer cleared.
